// File: rtl/token_pass_sequencer.sv
// Purpose: per-pass controller for a ROWS x COLS PE array: GLB weight load, token streaming into ifmap FIFOs, drain, done pulse.
// Latency: LOAD_W takes one cycle per weight plus one for GLB read latency; STREAM pushes at most one token per cycle; DONE lasts one cycle.
// Backpressure: any full active ifmap row or opsum column stalls STREAM (state and token count held); DRAIN waits for active ifmap FIFOs to empty.
// Optional build macro TOKEN_SEQ_PERF_EN adds stall_cycles_o / pass_cycles_o counters.
module token_pass_sequencer #(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pass_start_i,
    input  logic [1:0]                 layer_type_i,
    input  logic [ADDR_W-1:0]          weight_base_addr_i,
    input  logic [CNT_W-1:0]           tile_n_i,
    input  logic [$clog2(ROWS):0]      ic_real_i,
    input  logic [$clog2(COLS):0]      oc_real_i,
    output logic                       glb_rd_en_o,
    output logic [ADDR_W-1:0]          glb_addr_o,
    output logic [ROWS*COLS-1:0]       weight_load_en_o,
    output logic [ROWS-1:0]            push_ifmap_en_o,
    input  logic [ROWS-1:0]            ifmap_fifo_full_i,
    input  logic [ROWS-1:0]            ifmap_fifo_empty_i,
    input  logic [COLS-1:0]            opsum_fifo_full_i,
    output logic                       busy_o,
    output logic                       pass_done_o
`ifdef TOKEN_SEQ_PERF_EN
    ,
    output logic [31:0]                stall_cycles_o,
    output logic [31:0]                pass_cycles_o
`endif
);
    localparam int IC_W  = $clog2(ROWS) + 1;
    localparam int OC_W  = $clog2(COLS) + 1;
    localparam int IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam logic [ROWS*COLS-1:0] WL_ONE = {{(ROWS*COLS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic              is_dw;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  tile_q;
    logic [CNT_W-1:0]  token_cnt;
    logic [IC_W-1:0]   ic_q;
    logic [OC_W-1:0]   oc_q;
    logic [IC_W-1:0]   row_idx;
    logic [OC_W-1:0]   col_idx;
    logic              issue_done;
    logic              cap_vld;
    logic [IDX_W-1:0]  cap_idx;
    logic [IC_W-1:0]   ic_clamp;
    logic [OC_W-1:0]   oc_clamp;
    logic [ROWS-1:0]   row_mask;
    logic [COLS-1:0]   col_mask;
    logic              adv;
    logic              last_issue;
    logic              row_end;

    assign ic_clamp   = (ic_real_i > IC_W'(ROWS)) ? IC_W'(ROWS) : ic_real_i;
    assign oc_clamp   = (oc_real_i > OC_W'(COLS)) ? OC_W'(COLS) : oc_real_i;
    assign adv        = ~|(ifmap_fifo_full_i & row_mask) & ~|(opsum_fifo_full_i & col_mask);
    assign row_end    = is_dw || (col_idx == oc_q - OC_W'(1));
    assign last_issue = (row_idx == ic_q - IC_W'(1)) && row_end;
    // GLB data lands one cycle after the read, so the capture strobe follows the registered index
    assign weight_load_en_o = cap_vld ? (WL_ONE << cap_idx) : '0;

    // Thermometer masks of the active rows and columns for this pass
    always_comb begin
        row_mask = '0;
        col_mask = '0;
        for (int i = 0; i < ROWS; i++) row_mask[i] = (i < int'(ic_q));
        for (int j = 0; j < COLS; j++) col_mask[j] = (j < int'(oc_q));
    end

    // State register; reset aborts any pass without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state outputs
    always_comb begin
        state_nxt       = state;
        glb_rd_en_o     = 1'b0;
        glb_addr_o      = '0;
        push_ifmap_en_o = '0;
        pass_done_o     = 1'b0;
        busy_o          = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (pass_start_i)
                    state_nxt = (ic_clamp == '0 || oc_clamp == '0) ? DONE : LOAD_W;
            end
            LOAD_W: begin
                glb_rd_en_o = ~issue_done;
                glb_addr_o  = issue_done ? '0 : addr_q;
                if (cap_vld && issue_done)
                    state_nxt = (tile_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                if (adv) begin
                    push_ifmap_en_o = row_mask;
                    if (token_cnt == tile_q - CNT_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (&(ifmap_fifo_empty_i | ~row_mask)) state_nxt = DONE;
            end
            DONE: begin
                pass_done_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pass parameters, weight walk (address is sequential in visit order) and token count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_dw      <= 1'b0;
            addr_q     <= '0;
            tile_q     <= '0;
            token_cnt  <= '0;
            ic_q       <= '0;
            oc_q       <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            issue_done <= 1'b0;
            cap_vld    <= 1'b0;
            cap_idx    <= '0;
        end else begin
            cap_vld <= (state == LOAD_W) && glb_rd_en_o;
            case (state)
                IDLE: begin
                    if (pass_start_i) begin
                        is_dw      <= (layer_type_i == 2'd1);
                        addr_q     <= weight_base_addr_i;
                        tile_q     <= tile_n_i;
                        ic_q       <= ic_clamp;
                        oc_q       <= oc_clamp;
                        row_idx    <= '0;
                        col_idx    <= '0;
                        issue_done <= 1'b0;
                        token_cnt  <= '0;
                    end
                end
                LOAD_W: begin
                    if (glb_rd_en_o) begin
                        cap_idx <= IDX_W'(int'(row_idx) * COLS + (is_dw ? int'(row_idx) : int'(col_idx)));
                        addr_q  <= addr_q + ADDR_W'(1);
                        if (last_issue) begin
                            issue_done <= 1'b1;
                        end else if (row_end) begin
                            col_idx <= '0;
                            row_idx <= row_idx + IC_W'(1);
                        end else begin
                            col_idx <= col_idx + OC_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (adv) token_cnt <= token_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef TOKEN_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] pass_cnt;

    // Saturating pass-length and stall counters, cleared when a pass is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            pass_cnt  <= '0;
        end else if (state == IDLE) begin
            if (pass_start_i) begin
                stall_cnt <= '0;
                pass_cnt  <= '0;
            end
        end else begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 32'd1;
            if (state == STREAM && !adv && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign pass_cycles_o  = pass_cnt;
`endif

endmodule
